// File: rtl/osd_cmd_seq.sv
// osd_cmd_seq: round-robin sequencer driving control and line-write transactions onto the OSD command port.
// Define OSD_CMD_ROT_EN to append the rotation word to info-window control transactions.
module osd_cmd_seq #(
    parameter int GAP = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ctl_req,
    input  logic        ctl_enable,
    input  logic        ctl_info,
    input  logic [11:0] ctl_infox,
    input  logic [11:0] ctl_infoy,
    input  logic [5:0]  ctl_infow,
    input  logic [5:0]  ctl_infoh,
    input  logic [1:0]  ctl_rot,
    output logic        ctl_ack,
    input  logic        wr_req,
    input  logic [4:0]  wr_line,
    output logic        wr_ack,
    output logic        rd_en,
    output logic [7:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SETUP, S_HOLD, S_STROBE, S_POST, S_GAP} state_t;
    localparam logic [3:0] GAP_N = 4'(GAP);
`ifdef OSD_CMD_ROT_EN
    localparam logic [8:0] INFO_LAST = 9'd5;
`else
    localparam logic [8:0] INFO_LAST = 9'd4;
`endif
    state_t      state, state_nxt;
    logic [3:0]  gap_cnt;
    logic [8:0]  word, last_idx;
    logic        own_wr, rr_wr_last, l_enable, l_info;
    logic [11:0] l_x, l_y;
    logic [5:0]  l_w, l_h;
    logic [4:0]  l_line;
    logic [15:0] word_val, rot_word;
    logic        gap_ok, grant, grant_wr, last;
`ifdef OSD_CMD_ROT_EN
    logic [1:0]  l_rot;
    assign rot_word = {14'h0, l_rot};
`else
    logic        unused_rot;
    assign unused_rot = ^ctl_rot;
    assign rot_word   = 16'h0;
`endif
    // gap_cnt counts idle cycles since io_osd fell (or reset), saturating at GAP
    assign gap_ok   = gap_cnt == GAP_N;
    assign grant_wr = wr_req && !(ctl_req && rr_wr_last);
    assign grant    = state == S_IDLE && gap_ok && (ctl_req || wr_req);
    assign last_idx = own_wr ? 9'd256 : (l_enable && l_info) ? INFO_LAST : 9'd0;
    assign last     = word == last_idx;
    assign word_val = word == 9'd0 ? (own_wr ? {11'h001, l_line} : {8'h0, 5'b01000, l_info, 1'b0, l_enable}) :
                      own_wr       ? {8'h0, rd_data} :
                      word == 9'd1 ? {4'h0, l_x} :
                      word == 9'd2 ? {4'h0, l_y} :
                      word == 9'd3 ? {10'h0, l_w} :
                      word == 9'd4 ? {10'h0, l_h} : rot_word;
    assign io_osd    = state != S_IDLE && state != S_GAP;
    assign busy      = state != S_IDLE;
    assign io_strobe = state == S_STROBE;
    assign rd_en     = state == S_SETUP && own_wr && word != 9'd0;
    assign ctl_ack   = state == S_GAP && gap_cnt == 4'd0 && !own_wr;
    assign wr_ack    = state == S_GAP && gap_cnt == 4'd0 && own_wr;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = grant ? S_PRE : S_IDLE;
            S_PRE:    state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_HOLD;
            S_HOLD:   state_nxt = S_STROBE;
            S_STROBE: state_nxt = last ? S_POST : S_SETUP;
            S_POST:   state_nxt = S_GAP;
            S_GAP:    state_nxt = gap_cnt == GAP_N - 4'd1 ? S_IDLE : S_GAP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt    <= 4'd0;
            word       <= 9'd0;
            own_wr     <= 1'b0;
            rr_wr_last <= 1'b1;
            l_enable   <= 1'b0;
            l_info     <= 1'b0;
            l_x        <= 12'h0;
            l_y        <= 12'h0;
            l_w        <= 6'h0;
            l_h        <= 6'h0;
            l_line     <= 5'h0;
`ifdef OSD_CMD_ROT_EN
            l_rot      <= 2'h0;
`endif
            rd_addr    <= 8'h0;
            io_din     <= 16'h0;
        end else begin
            gap_cnt <= io_osd ? 4'd0 : gap_ok ? gap_cnt : gap_cnt + 4'd1;
            if (grant) begin
                own_wr     <= grant_wr;
                rr_wr_last <= grant_wr;
                word       <= 9'd0;
                l_enable   <= ctl_enable;
                l_info     <= ctl_info;
                l_x        <= ctl_infox;
                l_y        <= ctl_infoy;
                l_w        <= ctl_infow;
                l_h        <= ctl_infoh;
                l_line     <= wr_line;
`ifdef OSD_CMD_ROT_EN
                l_rot      <= ctl_rot;
`endif
                if (grant_wr) rd_addr <= 8'h0;
            end
            if (state == S_HOLD) io_din <= word_val;
            // the final byte leaves rd_addr at 255 so it never overflows mid-transaction
            if (state == S_STROBE && !last) begin
                word <= word + 9'd1;
                if (own_wr && word != 9'd0) rd_addr <= rd_addr + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_osd_cmd_seq.sv
// tb_osd_cmd_seq: randomized bench for osd_cmd_seq with a transaction-level reference model.
module tb_osd_cmd_seq;
    localparam int GAP = 3;
`ifdef OSD_CMD_ROT_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif
    logic        clk_sys = 1'b0, reset_n = 1'b1;
    logic        ctl_req = 1'b0, ctl_enable = 1'b0, ctl_info = 1'b0;
    logic [11:0] ctl_infox = 12'h0, ctl_infoy = 12'h0;
    logic [5:0]  ctl_infow = 6'h0, ctl_infoh = 6'h0;
    logic [1:0]  ctl_rot = 2'h0;
    logic        ctl_ack, wr_ack, rd_en, io_osd, io_strobe, busy;
    logic        wr_req = 1'b0;
    logic [4:0]  wr_line = 5'h0;
    logic [7:0]  rd_addr, rd_data = 8'h0;
    logic [15:0] io_din;
    int vectors = 0, miscompares = 0;
    logic [7:0]  mem [256];

    always #5 clk_sys = ~clk_sys;

    osd_cmd_seq #(.GAP(GAP)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ctl_req(ctl_req), .ctl_enable(ctl_enable), .ctl_info(ctl_info),
        .ctl_infox(ctl_infox), .ctl_infoy(ctl_infoy), .ctl_infow(ctl_infow), .ctl_infoh(ctl_infoh),
        .ctl_rot(ctl_rot), .ctl_ack(ctl_ack),
        .wr_req(wr_req), .wr_line(wr_line), .wr_ack(wr_ack),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .io_osd(io_osd), .io_strobe(io_strobe), .io_din(io_din), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // source memory: data appears the cycle after rd_en
    bit         pend_rd = 1'b0;
    logic [7:0] pend_addr = 8'h0;
    initial forever begin
        @(posedge clk_sys);
        #1;
        rd_data   = pend_rd ? mem[pend_addr] : 8'($urandom);
        pend_rd   = rd_en;
        pend_addr = rd_addr;
    end

    // reference model: requests seen at each edge, expected word list per transaction
    bit          s_ctl, s_wr, s_en, s_info, last_wr = 1'b1, prev_osd, owner_wr, fell;
    logic [11:0] s_x, s_y;
    logic [5:0]  s_w, s_h;
    logic [1:0]  s_rot;
    logic [4:0]  s_line;
    int          idle_cnt, pend_cnt, gap_rem, since_strobe = 100, osd_len, nwords, byte_k;
    logic [15:0] exp_q [$];

    initial forever begin
        @(negedge clk_sys);
        if (!reset_n) begin
            chk("rst_out", {io_osd, io_strobe, rd_en, ctl_ack, wr_ack, busy, rd_addr}, 0);
            chk("rst_din", io_din, 0);
            exp_q.delete();
            last_wr = 1'b1; owner_wr = 1'b0; prev_osd = 1'b0;
            idle_cnt = 0; pend_cnt = 0; gap_rem = 0; since_strobe = 100;
        end else begin
            fell = prev_osd && !io_osd;
            if (fell) begin
                chk("osd_len", osd_len, 3 * nwords + 2);
                chk("words_left", exp_q.size(), 0);
                if (owner_wr) chk("rd_count", byte_k, 256);
                gap_rem = GAP;
            end
            chk("ctl_ack", ctl_ack, fell && !owner_wr);
            chk("wr_ack", wr_ack, fell && owner_wr);
            chk("busy", busy, io_osd || gap_rem > 0);
            if (io_osd && !prev_osd) begin
                chk("idle_gap", idle_cnt >= GAP, 1);
                chk("grant_req", s_ctl || s_wr, 1);
                owner_wr = !(s_ctl && (!s_wr || last_wr));
                last_wr  = owner_wr;
                exp_q.delete();
                if (owner_wr) begin
                    exp_q.push_back(16'h0020 | 16'(s_line));
                    for (int k = 0; k < 256; k++) exp_q.push_back(16'(mem[k]));
                end else begin
                    exp_q.push_back(16'h0040 | (16'(s_info) << 2) | 16'(s_en));
                    if (s_en && s_info) begin
                        exp_q.push_back(16'(s_x));
                        exp_q.push_back(16'(s_y));
                        exp_q.push_back(16'(s_w));
                        exp_q.push_back(16'(s_h));
                        if (ROT) exp_q.push_back(16'(s_rot));
                    end
                end
                nwords = exp_q.size(); osd_len = 0; byte_k = 0;
            end
            if (io_osd) osd_len++;
            if (io_strobe) begin
                chk("strobe_space", since_strobe >= 3, 1);
                since_strobe = 0;
                if (exp_q.size() > 0) chk("io_din", io_din, exp_q.pop_front());
                else chk("extra_strobe", io_strobe, 0);
            end
            since_strobe++;
            if (rd_en) begin
                chk("rd_addr", rd_addr, byte_k);
                chk("rd_en_ctx", io_osd && owner_wr, 1);
                byte_k++;
            end
            if (!io_osd && gap_rem > 0) gap_rem--;
            pend_cnt = (!io_osd && gap_rem == 0 && (s_ctl || s_wr)) ? pend_cnt + 1 : 0;
            if (pend_cnt > GAP + 3) begin
                chk("grant_latency", pend_cnt, GAP + 3);
                pend_cnt = 0;
            end
            idle_cnt = io_osd ? 0 : idle_cnt + 1;
            prev_osd = io_osd;
        end
        s_ctl = ctl_req; s_wr = wr_req; s_en = ctl_enable; s_info = ctl_info;
        s_x = ctl_infox; s_y = ctl_infoy; s_w = ctl_infow; s_h = ctl_infoh;
        s_rot = ctl_rot; s_line = wr_line;
    end

    task automatic wait_ack(input bit wr);
        int n = 0;
        do begin
            @(posedge clk_sys);
            #1;
            n++;
        end while (!(wr ? wr_ack : ctl_ack) && n < 3000);
        if (n >= 3000) chk("ack_wait", wr ? wr_ack : ctl_ack, 1);
        if (wr) wr_req = 1'b0;
        else    ctl_req = 1'b0;
    endtask

    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        #1 chk("async_rst", {io_osd, io_strobe, rd_en, ctl_ack, wr_ack, busy, rd_addr}, 0);
        chk("async_din", io_din, 0);
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        @(posedge clk_sys);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = ~8'(k);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #2 reset_n = 1'b1;
        // single-word enable command
        ctl_enable = 1'b1; ctl_info = 1'b0; ctl_rot = 2'd2; ctl_req = 1'b1;
        wait_ack(1'b0);
        // info window; fields scrambled after grant
        ctl_enable = 1'b1; ctl_info = 1'b1; ctl_infox = 12'h010; ctl_infoy = 12'h020;
        ctl_infow = 6'd4; ctl_infoh = 6'd3; ctl_rot = 2'd1; ctl_req = 1'b1;
        repeat (8) @(posedge clk_sys);
        #1 {ctl_infox, ctl_infoy, ctl_infow, ctl_infoh, ctl_rot} = 38'($urandom) ^ {6'($urandom), 32'($urandom)};
        ctl_info = 1'b0;
        wait_ack(1'b0);
        // line 9 write with rd_data = ~rd_addr
        wr_line = 5'd9; wr_req = 1'b1;
        wait_ack(1'b1);
        // simultaneous requests right after reset
        pulse_reset();
        ctl_enable = 1'b1; ctl_info = 1'b1; ctl_req = 1'b1; wr_req = 1'b1; wr_line = 5'd17;
        wait_ack(1'b0);
        wait_ack(1'b1);
        // reset during byte 100, request held so the write restarts
        wr_line = 5'd3; wr_req = 1'b1;
        for (int n = 0; n < 2000 && !(rd_en && rd_addr == 8'd100); n++) begin
            @(posedge clk_sys);
            #1;
        end
        if (!(rd_en && rd_addr == 8'd100)) chk("byte100_wait", rd_addr, 100);
        pulse_reset();
        wait_ack(1'b1);
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk_sys);
            #1;
            {ctl_enable, ctl_info, ctl_rot} = 4'($urandom);
            ctl_infox = 12'($urandom); ctl_infoy = 12'($urandom);
            ctl_infow = 6'($urandom);  ctl_infoh = 6'($urandom);
            wr_line   = 5'($urandom);
            ctl_req = !ctl_req ? ($urandom_range(0, 5) == 0) :
                      ctl_ack  ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) != 0);
            wr_req  = !wr_req  ? ($urandom_range(0, 59) == 0) :
                      wr_ack   ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) != 0);
            if (i == 4000) pulse_reset();
        end
        ctl_req = 1'b0; wr_req = 1'b0;
        repeat (1000) @(posedge clk_sys);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
